// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//   Merges one-cycle debounced button pulses into an ordered event stream.
//   Each pulse latches a per-button pending bit. A round-robin arbiter moves
//   at most one pending button per cycle into a small FIFO. The consumer
//   drains the FIFO through a valid/ready handshake.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   btn_pulse  [NUM_BTN]  debounced one-cycle pulses, bit i = button i
//   ev_valid   FIFO head holds an event
//   ev_code    [CODE_W]   button index at the FIFO head
//   ev_ready   consumer accepts the head event
//   fifo_full  FIFO holds FIFO_DEPTH entries
//   overflow   sticky flag: a pulse was dropped
//   ovf_clr    synchronous clear of overflow (a same-cycle drop wins)
//
// Optional feature macro: BTN_REPEAT_LOCKOUT_EN
//   When defined, a granted button ignores further pulses for LOCKOUT_CYCLES
//   cycles. Ignored pulses set neither pending nor overflow.
module button_event_arbiter #(
  parameter int NUM_BTN        = 4,
  parameter int CODE_W         = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_pulse,
  output logic               ev_valid,
  output logic [CODE_W-1:0]  ev_code,
  input  logic               ev_ready,
  output logic               fifo_full,
  output logic               overflow,
  input  logic               ovf_clr
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LK_W  = $clog2(LOCKOUT_CYCLES + 1);

  if ((2 ** CODE_W) < NUM_BTN) begin : g_bad_code_w
    $error("CODE_W too narrow for NUM_BTN");
  end
  if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout
    $error("LOCKOUT_CYCLES must be at least 1");
  end

  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [CODE_W-1:0]  rr_ptr_q;
  logic [CODE_W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               overflow_q;

  logic               found, grant, pop, drop;
  logic [CODE_W-1:0]  gnt_idx;
  logic [NUM_BTN-1:0] locked;

  assign ev_valid  = (count_q != '0);
  assign ev_code   = mem_q[rd_ptr_q];
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign overflow  = overflow_q;
  assign pop       = ev_valid & ev_ready;

  // Round-robin scan starting at rr_ptr. It uses only registered state, so
  // a pop in this cycle cannot free a slot for a grant in this same cycle.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_BTN) idx = idx - NUM_BTN;
      if (!found && pending_q[idx]) begin
        found   = 1'b1;
        gnt_idx = CODE_W'(idx);
      end
    end
    grant = found && !fifo_full;
  end

`ifdef BTN_REPEAT_LOCKOUT_EN
  logic [LK_W-1:0] lock_q [NUM_BTN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) lock_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (grant && gnt_idx == CODE_W'(i)) lock_q[i] <= LK_W'(LOCKOUT_CYCLES);
        else if (lock_q[i] != '0)           lock_q[i] <= lock_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) locked[i] = (lock_q[i] != '0);
  end
`else
  assign locked = '0;
`endif

  // Pending update. Clear the granted bit first, then apply new pulses, so
  // that a pulse on the button being granted re-arms it without a drop.
  always_comb begin
    pending_d = pending_q;
    drop      = 1'b0;
    if (grant) pending_d[gnt_idx] = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn_pulse[i] && !locked[i]) begin
        if (pending_q[i] && !(grant && gnt_idx == CODE_W'(i))) drop = 1'b1;
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      pending_q <= pending_d;
      if (drop)         overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
      if (grant) begin
        mem_q[wr_ptr_q] <= gnt_idx;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        rr_ptr_q        <= (int'(gnt_idx) == NUM_BTN - 1) ? '0 : gnt_idx + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({grant, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_pulse;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic       ev_ready;
  logic       fifo_full;
  logic       overflow;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

  button_event_arbiter #(
    .NUM_BTN(4), .CODE_W(2), .FIFO_DEPTH(4), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .ev_valid(ev_valid),
    .ev_code(ev_code), .ev_ready(ev_ready), .fifo_full(fifo_full),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_pulse = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", ev_valid); end
    checks++; if (ev_code !== 2'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", ev_code); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", fifo_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
  endtask

  task automatic test_single();
    do_reset();
    btn_pulse = 4'b0100; ev_ready = 1'b1;
    tick(); btn_pulse = '0;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_c1_valid: got %0b expected 0", ev_valid); end
    tick();
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL single_c2_valid: got %0b expected 1", ev_valid); end
    checks++; if (ev_code !== 2'd2) begin errors++; $display("FAIL single_c2_code: got %0d expected 2", ev_code); end
    tick();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_c3_valid: got %0b expected 0", ev_valid); end
    ev_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int e1[3] = '{0, 1, 3};
    int e2[2] = '{0, 3};
    int e3[2] = '{3, 0};
    do_reset();
    btn_pulse = 4'b1011; tick(); btn_pulse = '0; tick(3);
    ev_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (ev_valid !== 1'b1 || ev_code !== 2'(e1[k])) begin errors++; $display("FAIL rr1_order[%0d]: got v=%0b code=%0d expected v=1 code=%0d", k, ev_valid, ev_code, e1[k]); end
      tick();
    end
    ev_ready = 1'b0;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rr1_empty: got %0b expected 0", ev_valid); end
    checks++; if (dut.rr_ptr_q !== 2'd0) begin errors++; $display("FAIL rr1_ptr: got %0d expected 0", dut.rr_ptr_q); end
    btn_pulse = 4'b1001; tick(); btn_pulse = '0; tick(3);
    ev_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (ev_valid !== 1'b1 || ev_code !== 2'(e2[k])) begin errors++; $display("FAIL rr2_order[%0d]: got v=%0b code=%0d expected v=1 code=%0d", k, ev_valid, ev_code, e2[k]); end
      tick();
    end
    // Grant button 2 first so the pointer sits at 3, reversing the order.
    do_reset();
    ev_ready = 1'b1;
    btn_pulse = 4'b0100; tick(); btn_pulse = '0; tick(3);
    ev_ready = 1'b0;
    checks++; if (dut.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL rr3_ptr: got %0d expected 3", dut.rr_ptr_q); end
    btn_pulse = 4'b1001; tick(); btn_pulse = '0; tick(3);
    ev_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (ev_valid !== 1'b1 || ev_code !== 2'(e3[k])) begin errors++; $display("FAIL rr3_order[%0d]: got v=%0b code=%0d expected v=1 code=%0d", k, ev_valid, ev_code, e3[k]); end
      tick();
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_full();
    int e[4] = '{1, 2, 3, 0};
    do_reset();
    btn_pulse = 4'b1111; tick(); btn_pulse = '0; tick(4);
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_c5: got %0b expected 1", fifo_full); end
    btn_pulse = 4'b0001; tick(); btn_pulse = '0;
    checks++; if (dut.pending_q[0] !== 1'b1) begin errors++; $display("FAIL full_pend_held: got %0b expected 1", dut.pending_q[0]); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %0b expected 0", overflow); end
    tick();
    checks++; if (fifo_full !== 1'b1 || ev_code !== 2'd0) begin errors++; $display("FAIL full_c7: got full=%0b code=%0d expected full=1 code=0", fifo_full, ev_code); end
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    checks++; if (fifo_full !== 1'b0 || ev_code !== 2'd1 || dut.pending_q[0] !== 1'b1) begin errors++; $display("FAIL full_after_pop: got full=%0b code=%0d pend0=%0b expected full=0 code=1 pend0=1", fifo_full, ev_code, dut.pending_q[0]); end
    tick();
    checks++; if (fifo_full !== 1'b1 || dut.pending_q[0] !== 1'b0) begin errors++; $display("FAIL full_refill: got full=%0b pend0=%0b expected full=1 pend0=0", fifo_full, dut.pending_q[0]); end
    ev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (ev_valid !== 1'b1 || ev_code !== 2'(e[k])) begin errors++; $display("FAIL full_drain[%0d]: got v=%0b code=%0d expected v=1 code=%0d", k, ev_valid, ev_code, e[k]); end
      tick();
    end
    ev_ready = 1'b0;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %0b expected 0", ev_valid); end
  endtask

  task automatic test_overflow();
    int e[5] = '{0, 1, 2, 3, 1};
    do_reset();
    btn_pulse = 4'b1111; tick(); btn_pulse = '0; tick(4);
    btn_pulse = 4'b0010; tick(); btn_pulse = '0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_first: got %0b expected 0", overflow); end
    tick();
    btn_pulse = 4'b0010; tick(); btn_pulse = '0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %0b expected 0", overflow); end
    btn_pulse = 4'b0010; ovf_clr = 1'b1; tick(); btn_pulse = '0; ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %0b expected 1", overflow); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr2: got %0b expected 0", overflow); end
    ev_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (ev_valid !== 1'b1 || ev_code !== 2'(e[k])) begin errors++; $display("FAIL ovf_drain[%0d]: got v=%0b code=%0d expected v=1 code=%0d", k, ev_valid, ev_code, e[k]); end
      tick();
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    btn_pulse = 4'b0111; tick();
    btn_pulse = 4'b0100; tick();
    btn_pulse = '0; tick(2);
    checks++; if (ev_valid !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL areset_pre: got v=%0b ovf=%0b expected v=1 ovf=1", ev_valid, overflow); end
    #3 rst = 1'b1;
    #1;
    checks++; if (ev_valid !== 1'b0 || fifo_full !== 1'b0 || overflow !== 1'b0 || ev_code !== 2'd0) begin errors++; $display("FAIL areset_now: got v=%0b full=%0b ovf=%0b code=%0d expected all 0", ev_valid, fifo_full, overflow, ev_code); end
    tick(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL areset_stale[%0d]: got %0b expected 0", k, ev_valid); end
    end
  endtask

  task automatic test_lockout();
    do_reset();
    ev_ready = 1'b1;
    btn_pulse = 4'b0001; tick(); btn_pulse = '0; tick();
    checks++; if (ev_valid !== 1'b1 || ev_code !== 2'd0) begin errors++; $display("FAIL lock_first: got v=%0b code=%0d expected v=1 code=0", ev_valid, ev_code); end
    tick(2);
    btn_pulse = 4'b0001; tick(); btn_pulse = '0;
`ifdef BTN_REPEAT_LOCKOUT_EN
    for (int k = 0; k < 4; k++) begin
      checks++; if (ev_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL lock_ignored[%0d]: got v=%0b ovf=%0b expected v=0 ovf=0", k, ev_valid, overflow); end
      tick();
    end
    tick(11);
    btn_pulse = 4'b0001; tick(); btn_pulse = '0; tick();
    checks++; if (ev_valid !== 1'b1 || ev_code !== 2'd0) begin errors++; $display("FAIL lock_expired: got v=%0b code=%0d expected v=1 code=0", ev_valid, ev_code); end
`else
    tick();
    checks++; if (ev_valid !== 1'b1 || ev_code !== 2'd0 || overflow !== 1'b0) begin errors++; $display("FAIL repeat_second: got v=%0b code=%0d ovf=%0b expected v=1 code=0 ovf=0", ev_valid, ev_code, overflow); end
`endif
    tick();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL lock_drained: got %0b expected 0", ev_valid); end
    ev_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_overflow();
    test_async_reset();
    test_lockout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
